// File: rtl/div_arbiter.sv
// div_arbiter
//
// Shares a single 8-bit sequential divide engine among NUM_REQ requesters.
// A round-robin arbiter picks one pending requester, latches its operands,
// fires one start request at the engine and waits for the done pulse.
// The result goes back to the winner, and the engine's local reset is pulsed
// for one cycle. The engine parks in its stop state after every division, so
// this pulse re-arms it for the next operation. A watchdog turns a silent
// engine into an error completion.
//
// Optional feature (macro DIV_ARB_ZERO_BYPASS_EN):
//   When defined, a winner whose divisor is zero never reaches the engine.
//   It completes one cycle after grant with {dividend, 8'hFF} and cli_err = 1.
//   The re-arm pulse still happens.
//   When undefined, a zero divisor is forwarded to the engine like any other.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   reset_n       asynchronous active-low reset
//   cli_req       per-requester level request, held until its cli_ack
//   cli_operands  requester i at [16i+15:16i] = {dividend, divisor}
//   cli_ack       one-cycle completion pulse to the granted requester
//   cli_result    {remainder, quotient}, held until the next completion
//   cli_err       1 = timeout or bypassed divide-by-zero, held like cli_result
//   busy          high in every state except IDLE
//   grant_id      index of the current or last granted requester
//   div_rst_n     engine reset = reset_n AND internal re-arm flop
//   div_req       one-cycle engine start request
//   div_valori    latched engine operands {dividend, divisor}
//   div_ack       engine one-cycle done pulse
//   div_result    engine result {remainder, quotient}
//
// NUM_REQ is expected in 2..8 and TIMEOUT_CYC >= 50.

module div_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 63,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     cli_req,
    input  logic [16*NUM_REQ-1:0]  cli_operands,
    output logic [NUM_REQ-1:0]     cli_ack,
    output logic [15:0]            cli_result,
    output logic                   cli_err,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   div_rst_n,
    output logic                   div_req,
    output logic [15:0]            div_valori,
    input  logic                   div_ack,
    input  logic [15:0]            div_result
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        REARM
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [15:0]          div_valori_q, div_valori_d;
    logic                 div_req_q, div_req_d;
    logic [NUM_REQ-1:0]   cli_ack_q, cli_ack_d;
    logic [15:0]          cli_result_q, cli_result_d;
    logic                 cli_err_q, cli_err_d;
    logic                 busy_q, busy_d;
    logic                 rearm_n_q, rearm_n_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        cnt_inc;

    logic                 found;
    logic [IDW-1:0]       winner;
    logic [15:0]          win_ops;
    int                   idx;
    logic [NUM_REQ-1:0]   req_sh;

    // Round-robin search: the first pending request at or after last+1,
    // wrapping around. Shifts rather than variable bit-selects keep the
    // index widths independent of NUM_REQ.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        win_ops = '0;
        idx     = 0;
        req_sh  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx    = (int'(last_q) + k) % NUM_REQ;
            req_sh = cli_req >> idx;
            if (!found && req_sh[0]) begin
                found   = 1'b1;
                winner  = IDW'(idx);
                win_ops = 16'(cli_operands >> (16 * idx));
            end
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    // Next-state logic for the arbiter FSM and all registered outputs.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_id_d   = grant_id_q;
        div_valori_d = div_valori_q;
        div_req_d    = 1'b0;
        cli_ack_d    = cli_ack_q;
        cli_result_d = cli_result_q;
        cli_err_d    = cli_err_q;
        rearm_n_d    = rearm_n_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    last_d       = winner;
                    grant_id_d   = winner;
                    div_valori_d = win_ops;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    // Zero divisor: answer locally, leave the engine idle.
                    if (win_ops[7:0] == 8'h00) begin
                        state_d      = REARM;
                        cli_result_d = {win_ops[15:8], 8'hFF};
                        cli_err_d    = 1'b1;
                        cli_ack_d    = NUM_REQ'(1) << winner;
                        rearm_n_d    = 1'b0;
                    end else begin
                        state_d   = ISSUE;
                        div_req_d = 1'b1;
                    end
`else
                    state_d   = ISSUE;
                    div_req_d = 1'b1;
`endif
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end

            WAIT: begin
                cnt_d = cnt_inc;
                // A done pulse arriving on the timeout cycle still wins.
                if (div_ack) begin
                    cli_result_d = div_result;
                    cli_err_d    = 1'b0;
                    cli_ack_d    = NUM_REQ'(1) << grant_id_q;
                    rearm_n_d    = 1'b0;
                    state_d      = REARM;
                end else if (cnt_inc == CW'(TIMEOUT_CYC)) begin
                    cli_result_d = 16'hFFFF;
                    cli_err_d    = 1'b1;
                    cli_ack_d    = NUM_REQ'(1) << grant_id_q;
                    rearm_n_d    = 1'b0;
                    state_d      = REARM;
                end
            end

            REARM: begin
                cli_ack_d = '0;
                rearm_n_d = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset puts the pointer on NUM_REQ-1 so
    // requester 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_q       <= IDW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            div_valori_q <= '0;
            div_req_q    <= 1'b0;
            cli_ack_q    <= '0;
            cli_result_q <= '0;
            cli_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            rearm_n_q    <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_id_q   <= grant_id_d;
            div_valori_q <= div_valori_d;
            div_req_q    <= div_req_d;
            cli_ack_q    <= cli_ack_d;
            cli_result_q <= cli_result_d;
            cli_err_q    <= cli_err_d;
            busy_q       <= busy_d;
            rearm_n_q    <= rearm_n_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cli_ack    = cli_ack_q;
    assign cli_result = cli_result_q;
    assign cli_err    = cli_err_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;
    assign div_req    = div_req_q;
    assign div_valori = div_valori_q;

    // Both terms come straight from flops, so the AND cannot glitch.
    assign div_rst_n  = reset_n & rearm_n_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
//
// Directed bench for div_arbiter. A transaction-level model predicts every
// output on every cycle from round-robin and integer-division rules. A small
// behavioural engine answers div_req after a programmable latency or stays
// silent. Hand-computed literals pin the model on the key scenarios.

module tb_div_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 63;
    localparam int IDW         = $clog2(NUM_REQ);

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_REQ-1:0]    cli_req = '0;
    logic [16*NUM_REQ-1:0] cli_operands = '0;
    logic [NUM_REQ-1:0]    cli_ack;
    logic [15:0]           cli_result;
    logic                  cli_err;
    logic                  busy;
    logic [IDW-1:0]        grant_id;
    logic                  div_rst_n;
    logic                  div_req;
    logic [15:0]           div_valori;
    logic                  div_ack = 1'b0;
    logic [15:0]           div_result = '0;

    div_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cli_req      (cli_req),
        .cli_operands (cli_operands),
        .cli_ack      (cli_ack),
        .cli_result   (cli_result),
        .cli_err      (cli_err),
        .busy         (busy),
        .grant_id     (grant_id),
        .div_rst_n    (div_rst_n),
        .div_req      (div_req),
        .div_valori   (div_valori),
        .div_ack      (div_ack),
        .div_result   (div_result)
    );

    always #5 clk = ~clk;

    // Engine behaviour shared by the engine process and the model.
    // A zero divisor yields {dividend, 8'hFF}.
    function automatic logic [15:0] divRef(input logic [15:0] ops);
        logic [7:0] a, b;
        a = ops[15:8];
        b = ops[7:0];
        if (b == 8'h00) return {a, 8'hFF};
        return {8'(a % b), 8'(a / b)};
    endfunction

    function automatic bit bitOf(input logic [NUM_REQ-1:0] v, input int i);
        logic [NUM_REQ-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // Engine: samples div_req just after a rising edge, then answers after
    // eng_lat cycles unless eng_silent is set or its reset drops meanwhile.
    int          eng_lat    = 3;
    bit          eng_silent = 1'b0;
    logic [15:0] eng_ops;
    bit          eng_abort;
    int          eng_n;
    always begin
        @(posedge clk);
        #1;
        if (div_req && div_rst_n && !eng_silent) begin
            eng_ops   = div_valori;
            eng_abort = 1'b0;
            eng_n     = eng_lat;
            for (int i = 0; i < eng_n && !eng_abort; i++) begin
                @(posedge clk);
                #1;
                if (!div_rst_n) eng_abort = 1'b1;
            end
            if (!eng_abort) begin
                div_result = divRef(eng_ops);
                div_ack    = 1'b1;
                @(posedge clk);
                #1;
                div_ack    = 1'b0;
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // Transaction model. Phase 0 = idle, 1 = operation in flight (m_cnt
    // edges left until the completion shows), 2 = completion visible.
    int             m_phase;
    int             m_cnt;
    int             m_last;
    logic [IDW-1:0] m_gid;
    logic [15:0]    m_ops, m_res, m_pend_res;
    bit             m_err, m_pend_err, m_issue;

    task automatic modelReset();
        m_phase = 0;
        m_cnt   = 0;
        m_last  = NUM_REQ - 1;
        m_gid   = '0;
        m_ops   = '0;
        m_res   = '0;
        m_err   = 1'b0;
        m_issue = 1'b0;
    endtask

    task automatic modelStep();
        int w;
        if (!reset_n) begin
            modelReset();
            return;
        end
        case (m_phase)
            0: begin
                w = -1;
                for (int k = 1; k <= NUM_REQ && w < 0; k++)
                    if (bitOf(cli_req, (m_last + k) % NUM_REQ)) w = (m_last + k) % NUM_REQ;
                if (w >= 0) begin
                    m_last = w;
                    m_gid  = IDW'(w);
                    m_ops  = 16'(cli_operands >> (16 * w));
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    if (m_ops[7:0] == 8'h00) begin
                        m_phase = 2;
                        m_res   = {m_ops[15:8], 8'hFF};
                        m_err   = 1'b1;
                        return;
                    end
`endif
                    m_phase = 1;
                    m_issue = 1'b1;
                    if (eng_silent || eng_lat > TIMEOUT_CYC) begin
                        m_cnt      = TIMEOUT_CYC + 1;
                        m_pend_res = 16'hFFFF;
                        m_pend_err = 1'b1;
                    end else begin
                        m_cnt      = eng_lat + 1;
                        m_pend_res = divRef(m_ops);
                        m_pend_err = 1'b0;
                    end
                end
            end
            1: begin
                m_issue = 1'b0;
                m_cnt--;
                if (m_cnt == 0) begin
                    m_phase = 2;
                    m_res   = m_pend_res;
                    m_err   = m_pend_err;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compareAll();
        logic [NUM_REQ-1:0] e_ack;
        e_ack = (m_phase == 2) ? (NUM_REQ'(1) << m_gid) : '0;
        checkOutput("cli_ack",    32'(cli_ack),    32'(e_ack));
        checkOutput("busy",       32'(busy),       32'(m_phase != 0));
        checkOutput("grant_id",   32'(grant_id),   32'(m_gid));
        checkOutput("cli_result", 32'(cli_result), 32'(m_res));
        checkOutput("cli_err",    32'(cli_err),    32'(m_err));
        checkOutput("div_req",    32'(div_req),    32'(m_issue));
        checkOutput("div_valori", 32'(div_valori), 32'(m_ops));
        checkOutput("div_rst_n",  32'(div_rst_n),  32'(reset_n && m_phase != 2));
    endtask

    // Client side bookkeeping and logs of every completion.
    int                 cyc = 0;
    int                 rearm_low = 0;
    int                 req_seen = 0;
    logic [NUM_REQ-1:0] rereq = '0;
    logic [NUM_REQ-1:0] raise_next = '0;
    int                 served[$];
    logic [15:0]        res_log[$];
    bit                 err_log[$];
    int                 gid_log[$];

    // One clock cycle: advance the model on the edge, compare just after,
    // then behave like the clients (drop on ack, optionally re-request).
    task automatic applyStimulus();
        logic [NUM_REQ-1:0] r;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
        if (!div_rst_n && reset_n) rearm_low++;
        if (div_req) req_seen++;
        r          = raise_next;
        raise_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bitOf(cli_ack, i)) begin
                served.push_back(i);
                res_log.push_back(cli_result);
                err_log.push_back(cli_err);
                gid_log.push_back(int'(grant_id));
                cli_req = cli_req & ~(NUM_REQ'(1) << i);
                if (bitOf(rereq, i)) raise_next = raise_next | (NUM_REQ'(1) << i);
            end
        end
        cli_req = cli_req | r;
        cyc++;
    endtask

    task automatic setOps(input int i, input logic [15:0] v);
        logic [16*NUM_REQ-1:0] mask, val;
        mask = {{(16*NUM_REQ-16){1'b0}}, 16'hFFFF} << (16 * i);
        val  = {{(16*NUM_REQ-16){1'b0}}, v} << (16 * i);
        cli_operands = (cli_operands & ~mask) | val;
    endtask

    task automatic raiseReq(input int i);
        cli_req = cli_req | (NUM_REQ'(1) << i);
    endtask

    task automatic waitServed(input int target, input int bound, input string name);
        int t;
        t = 0;
        while (served.size() < target && t < bound) begin
            applyStimulus();
            t++;
        end
        checkOutput(name, 32'(served.size() >= target), 32'd1);
    endtask

    int base, t0, lat, rl0, rs0, t;

    initial begin
        modelReset();

        // Reset state.
        repeat (3) applyStimulus();
        checkOutput("rst_busy",       32'(busy),       32'd0);
        checkOutput("rst_cli_ack",    32'(cli_ack),    32'd0);
        checkOutput("rst_grant_id",   32'(grant_id),   32'd0);
        checkOutput("rst_div_req",    32'(div_req),    32'd0);
        checkOutput("rst_div_valori", 32'(div_valori), 32'd0);
        checkOutput("rst_cli_result", 32'(cli_result), 32'd0);
        checkOutput("rst_div_rst_n",  32'(div_rst_n),  32'd0);
        reset_n = 1'b1;
        applyStimulus();
        checkOutput("rel_div_rst_n",  32'(div_rst_n),  32'd1);

        // Single request: 100 / 7 = 14 rem 2.
        base = served.size();
        setOps(0, 16'h6407);
        rl0 = rearm_low;
        raiseReq(0);
        t0 = cyc;
        waitServed(base + 1, 200, "t2_done");
        lat = cyc - t0;
        checkOutput("t2_latency", 32'(lat), 32'(2 + eng_lat));
        checkOutput("t2_who",     32'(served[base]),  32'd0);
        checkOutput("t2_result",  32'(res_log[base]), 32'h020E);
        checkOutput("t2_err",     32'(err_log[base]), 32'd0);
        repeat (3) applyStimulus();
        checkOutput("t2_rearm_cycles", 32'(rearm_low - rl0), 32'd1);
        checkOutput("t2_busy_after",   32'(busy), 32'd0);

        // Two simultaneous requests: 200/13 = 15 r5, 255/1 = 255 r0.
        base = served.size();
        setOps(1, 16'hC80D);
        setOps(3, 16'hFF01);
        raiseReq(1);
        raiseReq(3);
        waitServed(base + 2, 200, "t3_done");
        checkOutput("t3_first",   32'(served[base]),      32'd1);
        checkOutput("t3_gid0",    32'(gid_log[base]),     32'd1);
        checkOutput("t3_res0",    32'(res_log[base]),     32'h050F);
        checkOutput("t3_second",  32'(served[base + 1]),  32'd3);
        checkOutput("t3_gid1",    32'(gid_log[base + 1]), 32'd3);
        checkOutput("t3_res1",    32'(res_log[base + 1]), 32'h00FF);

        // Four requesters hammering continuously: strict rotation.
        base = served.size();
        setOps(0, 16'h6407);
        setOps(1, 16'h3005);
        setOps(2, 16'h0902);
        setOps(3, 16'hF00F);
        rereq = '1;
        for (int i = 0; i < NUM_REQ; i++) raiseReq(i);
        waitServed(base + 8, 400, "t4_done");
        rereq = '0;
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("t4_order%0d", i), 32'(served[base + i]), 32'(i % NUM_REQ));
        t = 0;
        while ((cli_req != '0 || raise_next != '0 || busy) && t < 200) begin
            applyStimulus();
            t++;
        end
        checkOutput("t4_drained", 32'(cli_req), 32'd0);

        // Silent engine: error completion after the watchdog, then a normal op.
        base = served.size();
        eng_silent = 1'b1;
        setOps(2, 16'h6407);
        raiseReq(2);
        t0 = cyc;
        waitServed(base + 1, TIMEOUT_CYC + 20, "t5_done");
        lat = cyc - t0;
        checkOutput("t5_latency", 32'(lat), 32'(TIMEOUT_CYC + 2));
        checkOutput("t5_result",  32'(res_log[base]), 32'hFFFF);
        checkOutput("t5_err",     32'(err_log[base]), 32'd1);
        eng_silent = 1'b0;
        applyStimulus();
        setOps(3, 16'h0A03);
        raiseReq(3);
        waitServed(base + 2, 200, "t5b_done");
        checkOutput("t5b_result", 32'(res_log[base + 1]), 32'h0103);
        checkOutput("t5b_err",    32'(err_log[base + 1]), 32'd0);

        // Reset mid-operation: aborted op gives no ack, req2 re-granted first.
        applyStimulus();
        base = served.size();
        eng_lat = 10;
        setOps(2, 16'h0804);
        rs0 = req_seen;
        raiseReq(2);
        t = 0;
        while (req_seen == rs0 && t < 20) begin
            applyStimulus();
            t++;
        end
        checkOutput("t6_issued", 32'(req_seen > rs0), 32'd1);
        repeat (3) applyStimulus();
        reset_n = 1'b0;
        applyStimulus();
        checkOutput("t6_div_rst_n", 32'(div_rst_n), 32'd0);
        checkOutput("t6_busy",      32'(busy),      32'd0);
        checkOutput("t6_no_ack",    32'(served.size()), 32'(base));
        eng_lat = 3;
        applyStimulus();
        reset_n = 1'b1;
        waitServed(base + 1, 200, "t6_done");
        checkOutput("t6_regrant", 32'(served[base]),  32'd2);
        checkOutput("t6_result",  32'(res_log[base]), 32'h0002);

        // Zero divisor: 0x2A00.
        applyStimulus();
        base = served.size();
        rs0  = req_seen;
        setOps(0, 16'h2A00);
        raiseReq(0);
        t0 = cyc;
        waitServed(base + 1, 200, "t7_done");
        lat = cyc - t0;
        checkOutput("t7_result", 32'(res_log[base]), 32'h2AFF);
`ifdef DIV_ARB_ZERO_BYPASS_EN
        checkOutput("t7_err",     32'(err_log[base]),  32'd1);
        checkOutput("t7_latency", 32'(lat),            32'd1);
        checkOutput("t7_no_req",  32'(req_seen - rs0), 32'd0);
`else
        checkOutput("t7_err",     32'(err_log[base]),  32'd0);
        checkOutput("t7_latency", 32'(lat),            32'(2 + eng_lat));
        checkOutput("t7_req",     32'(req_seen - rs0), 32'd1);
`endif
        repeat (3) applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
